// File: rtl/oversample_phase_aligner.sv
// oversample_phase_aligner: per-channel edge histogramming of oversampled data and selection
// of the sample phase farthest from transitions, with lock/hysteresis and error counting.
module oversample_phase_aligner #(
    parameter int NCHAN            = 1,
    parameter int BPC              = 2,
    parameter int OSR              = 4,
    parameter int WINDOW_LOG2      = 6,
    parameter int LOCK_COUNT       = 3,
    parameter int LOCK_HOLD        = 4,
    parameter bit PHASE_SEL_MANUAL = 1'b0,
    localparam int PW = $clog2(OSR),
    localparam int NS = BPC * OSR
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [NCHAN*NS-1:0]   i_samples,
    input  logic [NCHAN*PW-1:0]   i_phase_sel_in,
    input  logic                  i_err_cnt_reset,
    output logic [NCHAN*BPC-1:0]  o_d_out,
    output logic [NCHAN*PW-1:0]   o_phase_sel_out,
    output logic [NCHAN-1:0]      o_locked,
    output logic [NCHAN-1:0]      o_phase_change,
    output logic [NCHAN-1:0]      o_phase_err,
    output logic [NCHAN*16-1:0]   o_err_cnt
);
    typedef enum logic {HUNT, LOCKED} state_t;

    logic [WINDOW_LOG2-1:0] r_win;
    logic                   w_win_end;

    assign w_win_end = &r_win;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_win <= '0;
        else            r_win <= r_win + 1'b1;
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_ch
        logic [NS-1:0]          r_s;
        logic                   r_prev;
        logic [NS:0]            w_stream;
        logic [OSR-1:0]         r_e, w_e;
        logic [OSR-1:0]         w_bits [BPC];
        logic [BPC-1:0]         r_d, w_d;
        logic [WINDOW_LOG2:0]   r_cnt [OSR];
        logic [WINDOW_LOG2:0]   w_sum [OSR];
        logic [WINDOW_LOG2:0]   w_best;
        logic [PW-1:0]          w_bidx, w_cand, w_sel_p1;
        state_t                 r_state, w_state_nx;
        logic [PW-1:0]          r_sel, w_sel_nx;
        logic [7:0]             r_match, w_match_nx, r_dis, w_dis_nx;
        logic                   r_pc, r_perr;
        logic [15:0]            r_err;

        // sample stream with the previous clock's last sample prepended as index -1
        assign w_stream = {r_s, r_prev};
        assign w_sel_p1 = r_sel + 1'b1;

        always_comb begin
            w_e = '0;
            for (int k = 0; k < NS; k++)
                w_e[k % OSR] = w_e[k % OSR] | (w_stream[k+1] ^ w_stream[k]);
        end

        always_comb begin
            for (int b = 0; b < BPC; b++) begin
                w_bits[b] = r_s[b*OSR +: OSR];
                w_d[b]    = w_bits[b][r_sel];
            end
        end

        // closing-window totals include this clock's e_r; strict compare keeps the lowest phase on ties
        always_comb begin
            w_best = '0;
            w_bidx = '0;
            for (int p = 0; p < OSR; p++) begin
                w_sum[p] = r_cnt[p] + {{WINDOW_LOG2{1'b0}}, r_e[p]};
                if (w_sum[p] > w_best) begin
                    w_best = w_sum[p];
                    w_bidx = PW'(p);
                end
            end
            w_cand = w_bidx + PW'(OSR / 2);
        end

        always_comb begin
            w_state_nx = r_state;
            w_sel_nx   = r_sel;
            w_match_nx = r_match;
            w_dis_nx   = r_dis;
            if (PHASE_SEL_MANUAL) begin
                w_sel_nx = i_phase_sel_in[c*PW +: PW];
            end else if (w_win_end && w_best != '0) begin
                if (r_state == HUNT) begin
                    w_sel_nx   = w_cand;
                    w_match_nx = (w_cand == r_sel) ? r_match + 1'b1 : 8'd1;
                    if (w_match_nx == 8'(LOCK_COUNT)) begin
                        w_state_nx = LOCKED;
                        w_match_nx = '0;
                    end
                end else if (w_cand == r_sel) begin
                    w_dis_nx = '0;
                end else begin
                    w_dis_nx = r_dis + 1'b1;
                    if (w_dis_nx == 8'(LOCK_HOLD)) begin
                        w_sel_nx = w_cand;
                        w_dis_nx = '0;
                    end
                end
            end
        end

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_s     <= '0;
                r_prev  <= 1'b0;
                r_e     <= '0;
                r_d     <= '0;
                for (int p = 0; p < OSR; p++) r_cnt[p] <= '0;
                r_state <= HUNT;
                r_sel   <= '0;
                r_match <= '0;
                r_dis   <= '0;
                r_pc    <= 1'b0;
                r_perr  <= 1'b0;
                r_err   <= '0;
            end else begin
                r_s     <= i_samples[c*NS +: NS];
                r_prev  <= r_s[NS-1];
                r_e     <= w_e;
                r_d     <= w_d;
                for (int p = 0; p < OSR; p++) r_cnt[p] <= w_win_end ? '0 : w_sum[p];
                r_state <= w_state_nx;
                r_sel   <= w_sel_nx;
                r_match <= w_match_nx;
                r_dis   <= w_dis_nx;
                r_pc    <= !PHASE_SEL_MANUAL && (w_sel_nx != r_sel);
                r_perr  <= r_e[r_sel] | r_e[w_sel_p1];
                if (i_err_cnt_reset)
                    r_err <= '0;
                else if (r_perr && r_state == LOCKED && r_err != 16'hFFFF)
                    r_err <= r_err + 1'b1;
            end
        end

        assign o_d_out[c*BPC +: BPC]       = r_d;
        assign o_phase_sel_out[c*PW +: PW] = r_sel;
        assign o_locked[c]                 = (r_state == LOCKED);
        assign o_phase_change[c]           = r_pc;
        assign o_phase_err[c]              = r_perr;
        assign o_err_cnt[c*16 +: 16]       = r_err;
    end
endmodule

// File: tb/tb_oversample_phase_aligner.sv
// tb_oversample_phase_aligner: auto and manual instances on a shared sample bus, compared
// every cycle against a window-level behavioural model plus hand-computed scenario checks.
module tb_oversample_phase_aligner;
    localparam int OSR = 4;
    localparam int BPC = 2;
    localparam int NS  = OSR * BPC;
    localparam int WIN = 64;
    localparam int LC  = 3;
    localparam int LH  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NS-1:0] samples = '0;
    logic [1:0]    psi = 2'd2;
    logic          ecr = 1'b0;
    logic [1:0]    d_out, sel, d2, sel2;
    logic          locked, pc, perr, locked2, pc2, perr2;
    logic [15:0]   err, err2;
    logic [1:0]    unused_psi = '0;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  checking = 0;

    oversample_phase_aligner dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_samples(samples), .i_phase_sel_in(unused_psi),
        .i_err_cnt_reset(ecr), .o_d_out(d_out), .o_phase_sel_out(sel), .o_locked(locked),
        .o_phase_change(pc), .o_phase_err(perr), .o_err_cnt(err)
    );

    oversample_phase_aligner #(.PHASE_SEL_MANUAL(1'b1)) dut_man (
        .i_clock(clk), .i_reset_n(rst_n), .i_samples(samples), .i_phase_sel_in(psi),
        .i_err_cnt_reset(ecr), .o_d_out(d2), .o_phase_sel_out(sel2), .o_locked(locked2),
        .o_phase_change(pc2), .o_phase_err(perr2), .o_err_cnt(err2)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: sample history, per-window edge histogram, phase decision per window
    bit [NS-1:0]  m_x;
    bit           m_prev;
    bit [OSR-1:0] m_e;
    int           m_hist [OSR];
    int           m_clk, m_sel, m_match, m_dis, m_err, mm_sel;
    bit           m_locked, m_pc, m_perr, mm_perr;
    bit [BPC-1:0] m_d, mm_d;

    function automatic bit [OSR-1:0] edges(input bit [NS-1:0] v, input bit pb);
        bit [NS:0] st;
        st = {v, pb};
        edges = '0;
        for (int k = 0; k < NS; k++)
            if (st[k+1] != st[k]) edges[k % OSR] = 1'b1;
    endfunction

    task automatic mreset();
        m_x = '0; m_prev = 0; m_e = '0; m_hist = '{default:0};
        m_clk = 0; m_sel = 0; m_match = 0; m_dis = 0; m_err = 0; mm_sel = 0;
        m_locked = 0; m_pc = 0; m_perr = 0; mm_perr = 0; m_d = '0; mm_d = '0;
    endtask

    task automatic mstep();
        bit [BPC-1:0] nd, nd2;
        bit           np, np2;
        int           nsel, nerr, best, tot, cand;
        for (int b = 0; b < BPC; b++) begin
            nd[b]  = m_x[b*OSR + m_sel];
            nd2[b] = m_x[b*OSR + mm_sel];
        end
        np   = m_e[m_sel] | m_e[(m_sel + 1) % OSR];
        np2  = m_e[mm_sel] | m_e[(mm_sel + 1) % OSR];
        nerr = ecr ? 0 : (m_perr && m_locked && m_err < 65535) ? m_err + 1 : m_err;
        nsel = m_sel;
        for (int p = 0; p < OSR; p++) m_hist[p] += int'(m_e[p]);
        m_clk++;
        if (m_clk == WIN) begin
            best = 0;
            tot  = 0;
            for (int p = 0; p < OSR; p++) begin
                tot += m_hist[p];
                if (m_hist[p] > m_hist[best]) best = p;
            end
            cand = (best + OSR / 2) % OSR;
            if (tot > 0) begin
                if (!m_locked) begin
                    m_match = (cand == m_sel) ? m_match + 1 : 1;
                    nsel = cand;
                    if (m_match == LC) begin
                        m_locked = 1;
                        m_match  = 0;
                    end
                end else if (cand == m_sel) begin
                    m_dis = 0;
                end else begin
                    m_dis++;
                    if (m_dis == LH) begin
                        nsel  = cand;
                        m_dis = 0;
                    end
                end
            end
            m_hist = '{default:0};
            m_clk  = 0;
        end
        m_pc   = (nsel != m_sel);
        m_sel  = nsel;
        m_d    = nd;
        m_perr = np;
        m_err  = nerr;
        mm_sel = int'(psi);
        mm_d   = nd2;
        mm_perr = np2;
        m_e    = edges(m_x, m_prev);
        m_prev = m_x[NS-1];
        m_x    = samples;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep();
        end
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            check("d_out", 32'(d_out), 32'(m_d));
            check("phase_sel_out", 32'(sel), 32'(m_sel));
            check("locked", 32'(locked), 32'(m_locked));
            check("phase_change", 32'(pc), 32'(m_pc));
            check("phase_err", 32'(perr), 32'(m_perr));
            check("err_cnt", 32'(err), 32'(m_err));
            check("man_d_out", 32'(d2), 32'(mm_d));
            check("man_phase_sel_out", 32'(sel2), 32'(mm_sel));
            check("man_locked", 32'(locked2), 32'd0);
            check("man_phase_change", 32'(pc2), 32'd0);
            check("man_phase_err", 32'(perr2), 32'(mm_perr));
            check("man_err_cnt", 32'(err2), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

    function automatic bit [NS-1:0] mk(input bit [BPC-1:0] bits, input bit last, input int ph);
        bit [BPC:0] st;
        st = {bits, last};
        for (int b = 0; b < BPC; b++)
            for (int p = 0; p < OSR; p++)
                mk[b*OSR + p] = (p < ph) ? st[b] : st[b+1];
    endfunction

    int           ph, phe;
    bit [BPC-1:0] rbits;
    bit           rlast;

    initial begin
        #2 rst_n = 1'b0;
        checking = 1;
        repeat (3) @(negedge clk);
        check("rst_d_out", 32'(d_out), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err_cnt", 32'(err), 0);
        rst_n = 1'b1;
        samples = 8'h1E;
        @(negedge clk);
        check("man_sel_after_1clk", 32'(sel2), 2);
        repeat (63) @(negedge clk);
        check("lock_sel_w1", 32'(sel), 3);
        check("lock_unlocked_w1", 32'(locked), 0);
        check("man_d_out_s2_s6", 32'(d2), 32'h1);
        repeat (127) @(negedge clk);
        check("lock_not_yet", 32'(locked), 0);
        @(negedge clk);
        check("lock_w3", 32'(locked), 1);
        check("lock_sel", 32'(sel), 3);
        check("lock_d_out", 32'(d_out), 32'h1);
        check("lock_perr", 32'(perr), 0);
        samples = '0;
        repeat (640) @(negedge clk);
        check("idle_sel", 32'(sel), 3);
        check("idle_locked", 32'(locked), 1);
        check("idle_perr", 32'(perr), 0);
        samples = 8'h3C;
        repeat (255) @(negedge clk);
        check("drift_hold_sel", 32'(sel), 3);
        @(negedge clk);
        check("drift_new_sel", 32'(sel), 0);
        check("drift_pc_pulse", 32'(pc), 1);
        @(negedge clk);
        check("drift_pc_single", 32'(pc), 0);
        for (int seg = 0; seg < 4; seg++) begin
            ph = $urandom_range(0, OSR - 1);
            for (int i = 0; i < 320; i++) begin
                rbits = 2'($urandom);
                phe = ($urandom_range(0, 7) == 0 && ph < OSR - 1) ? ph + 1 : ph;
                samples = mk(rbits, rlast, phe);
                rlast = rbits[BPC-1];
                ecr = ($urandom_range(0, 7) == 0);
                psi = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
        end
        ecr = 1'b0;
        psi = 2'd2;
        check("pre_reset_locked", 32'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_d_out", 32'(d_out), 0);
        check("midrst_sel", 32'(sel), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_perr", 32'(perr), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_man_sel", 32'(sel2), 0);
        check("midrst_man_d_out", 32'(d2), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        samples = 8'h1E;
        repeat (64) @(negedge clk);
        check("relock_sel_w1", 32'(sel), 3);
        check("relock_unlocked_w1", 32'(locked), 0);
        repeat (128) @(negedge clk);
        check("relock_w3", 32'(locked), 1);
        samples = 8'h66;
        repeat (70) @(negedge clk);
        check("sat_perr_on", 32'(perr), 1);
        ecr = 1'b1;
        @(negedge clk);
        ecr = 1'b0;
        check("ecr_priority", 32'(err), 0);
        @(negedge clk);
        check("ecr_resume", 32'(err), 1);
        repeat (65536) @(negedge clk);
        check("sat_ffff", 32'(err), 32'hFFFF);
        repeat (3) @(negedge clk);
        check("sat_hold", 32'(err), 32'hFFFF);
        ecr = 1'b1;
        @(negedge clk);
        ecr = 1'b0;
        check("sat_clear", 32'(err), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
